// File: rtl/fwd_sel_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fwd_sel_ctrl_pkg
// Brief   : Shared select codes, shadow-pipe entry type and match helper.
// Revision: 1.0 - initial release
// ============================================================================
package fwd_sel_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_EX  = 2'd1;
    localparam logic [1:0] SEL_MEM = 2'd2;
    localparam logic [1:0] SEL_WB  = 2'd3;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dst;
        logic                  wen;
        logic                  isload;
    } shadow_entry_t;

    localparam shadow_entry_t SHADOW_BUBBLE = '0;

    // $0 is hardwired, so it never matches a producer
    function automatic logic entry_hit(input shadow_entry_t e,
                                       input logic [REG_ADDR_W-1:0] src);
        return e.valid & e.wen & (e.dst == src) & (src != '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_src_cmp.sv
`default_nettype none
// ============================================================================
// Module  : fwd_src_cmp
// Brief   : Resolves one source operand against EX/MEM/WB shadow entries.
// Revision: 1.0 - initial release
// ============================================================================
module fwd_src_cmp
    import fwd_sel_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  use_src,
    input  logic                  id_valid,
    input  shadow_entry_t         ex_e,
    input  shadow_entry_t         mem_e,
    input  shadow_entry_t         wb_e,
    output logic [1:0]            sel,
    output logic                  loaduse
);

    logic w_active;
    logic w_ex_hit;
    logic w_mem_hit;
    logic w_wb_hit;
    logic w_unused;

    assign w_active  = id_valid & use_src;
    assign w_ex_hit  = w_active & entry_hit(ex_e, src);
    assign w_mem_hit = w_active & entry_hit(mem_e, src);
    assign w_wb_hit  = w_active & entry_hit(wb_e, src);
    assign w_unused  = ^{mem_e.isload, wb_e.isload};

    // youngest producer wins
    always_comb begin
        sel = SEL_RF;
        if (w_ex_hit) begin
            sel = SEL_EX;
        end else if (w_mem_hit) begin
            sel = SEL_MEM;
        end else if (w_wb_hit) begin
            sel = SEL_WB;
        end
    end

    assign loaduse = w_ex_hit & ex_e.isload;

endmodule
`default_nettype wire

// File: rtl/fwd_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fwd_sel_ctrl
// Brief   : ID-stage forwarding select and stall control with shadow pipe.
// Revision: 1.0 - initial release
// ============================================================================
module fwd_sel_ctrl
    import fwd_sel_ctrl_pkg::*;
#(
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int DIV_LAT = 32
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iIdValid,
    input  logic [ADDR_W-1:0] iIdRs,
    input  logic [ADDR_W-1:0] iIdRt,
    input  logic              iIdUseRs,
    input  logic              iIdUseRt,
    input  logic [ADDR_W-1:0] iIdDst,
    input  logic              iIdWen,
    input  logic              iIdIsLoad,
    input  logic              iIdIsDiv,
    input  logic              iFlush,
    output logic [1:0]        oSelA,
    output logic [1:0]        oSelB,
    output logic              oStall
);

    localparam int CNT_W = $clog2(DIV_LAT + 1);

    shadow_entry_t    r_ex;
    shadow_entry_t    r_mem;
    shadow_entry_t    r_wb;
    logic [CNT_W-1:0] r_div_cnt;

    shadow_entry_t    w_id_entry;
    logic [1:0]       w_sel_a;
    logic [1:0]       w_sel_b;
    logic             w_lu_a;
    logic             w_lu_b;
    logic             w_stall;
    logic             w_issue;

    fwd_src_cmp u_cmp_rs (
        .src      (REG_ADDR_W'(iIdRs)),
        .use_src  (iIdUseRs),
        .id_valid (iIdValid),
        .ex_e     (r_ex),
        .mem_e    (r_mem),
        .wb_e     (r_wb),
        .sel      (w_sel_a),
        .loaduse  (w_lu_a)
    );

    fwd_src_cmp u_cmp_rt (
        .src      (REG_ADDR_W'(iIdRt)),
        .use_src  (iIdUseRt),
        .id_valid (iIdValid),
        .ex_e     (r_ex),
        .mem_e    (r_mem),
        .wb_e     (r_wb),
        .sel      (w_sel_b),
        .loaduse  (w_lu_b)
    );

    // flush outranks any stall: a killed slot has nothing to hold
    assign w_stall = iIdValid & ~iFlush & (w_lu_a | w_lu_b | (r_div_cnt != '0));
    assign w_issue = iIdValid & ~w_stall & ~iFlush;

    always_comb begin
        w_id_entry        = SHADOW_BUBBLE;
        w_id_entry.valid  = 1'b1;
        w_id_entry.dst    = REG_ADDR_W'(iIdDst);
        w_id_entry.wen    = iIdWen;
        w_id_entry.isload = iIdIsLoad;
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_ex      <= SHADOW_BUBBLE;
            r_mem     <= SHADOW_BUBBLE;
            r_wb      <= SHADOW_BUBBLE;
            r_div_cnt <= '0;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= w_issue ? w_id_entry : SHADOW_BUBBLE;
            if (w_issue && iIdIsDiv) begin
                r_div_cnt <= CNT_W'(DIV_LAT);
            end else if (r_div_cnt != '0) begin
                r_div_cnt <= r_div_cnt - CNT_W'(1);
            end
        end
    end

    assign oSelA  = iRst_n ? w_sel_a : SEL_RF;
    assign oSelB  = iRst_n ? w_sel_b : SEL_RF;
    assign oStall = iRst_n & w_stall;

endmodule
`default_nettype wire

// File: tb/tb_fwd_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_fwd_sel_ctrl
// Brief   : Scoreboard bench for fwd_sel_ctrl against an instruction-history model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fwd_sel_ctrl;

    localparam int C_DIV_LAT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_dst;
    logic       use_rs, use_rt, id_wen, id_ld, id_div, flush;
    logic [1:0] sel_a, sel_b;
    logic       stall;

    always #5 clk = ~clk;

    fwd_sel_ctrl #(.ADDR_W(5), .DIV_LAT(C_DIV_LAT)) dut (
        .iClk      (clk),
        .iRst_n    (rst_n),
        .iIdValid  (id_valid),
        .iIdRs     (id_rs),
        .iIdRt     (id_rt),
        .iIdUseRs  (use_rs),
        .iIdUseRt  (use_rt),
        .iIdDst    (id_dst),
        .iIdWen    (id_wen),
        .iIdIsLoad (id_ld),
        .iIdIsDiv  (id_div),
        .iFlush    (flush),
        .oSelA     (sel_a),
        .oSelB     (sel_b),
        .oStall    (stall)
    );

    typedef struct { bit valid; int dst; bit wen; bit ld; } inst_t;
    typedef struct { int sa; int sb; bit st; } exp_t;

    // most recently issued instructions, youngest first
    inst_t hist[3];
    int    busy_end = -1;
    int    cyc = 0;
    exp_t  expq[$];
    int    total = 0;
    int    bad = 0;

    function automatic int model_sel(input int src);
        if (src == 0) return 0;
        for (int k = 0; k < 3; k++)
            if (hist[k].valid && hist[k].wen && hist[k].dst == src) return k + 1;
        return 0;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    task automatic step(input bit r, input bit v, input int rs, input int rt,
                        input bit urs, input bit urt, input int dst, input bit wen,
                        input bit ld, input bit dv, input bit fl);
        exp_t e;
        bit   lu;
        bit   issue;
        rst_n = r; id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt);
        use_rs = urs; use_rt = urt; id_dst = 5'(dst); id_wen = wen;
        id_ld = ld; id_div = dv; flush = fl;
        e = '{0, 0, 1'b0};
        if (r) begin
            e.sa = (v && urs) ? model_sel(rs) : 0;
            e.sb = (v && urt) ? model_sel(rt) : 0;
            lu   = hist[0].ld && (e.sa == 1 || e.sb == 1);
            e.st = v && !fl && (lu || cyc <= busy_end);
        end
        expq.push_back(e);
        @(posedge clk);
        #1;
        if (!r) begin
            for (int k = 0; k < 3; k++) hist[k] = '{1'b0, 0, 1'b0, 1'b0};
            busy_end = -1;
        end else begin
            issue   = v && !e.st && !fl;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = issue ? inst_t'{1'b1, dst, wen, ld} : inst_t'{1'b0, 0, 1'b0, 1'b0};
            if (issue && dv) busy_end = cyc + C_DIV_LAT;
        end
        cyc++;
    endtask

    task automatic ins(input int rs, input int rt, input int dst, input bit ld, input bit dv);
        step(1'b1, 1'b1, rs, rt, 1'b1, 1'b1, dst, 1'b1, ld, dv, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("selA",  int'(sel_a), e.sa);
                chk("selB",  int'(sel_b), e.sb);
                chk("stall", int'(stall), int'(e.st));
            end
        end
    end

    initial begin : stim
        int guard;
        for (int k = 0; k < 3; k++) hist[k] = '{1'b0, 0, 1'b0, 1'b0};
        rst_n = 1'b0; id_valid = 1'b0; id_rs = '0; id_rt = '0; use_rs = 1'b0;
        use_rt = 1'b0; id_dst = '0; id_wen = 1'b0; id_ld = 1'b0; id_div = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1;
        // reset with a hazard-looking ID slot
        step(1'b0, 1'b1, 3, 3, 1'b1, 1'b1, 3, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 3, 3, 1'b1, 1'b1, 3, 1'b1, 1'b1, 1'b1, 1'b0);
        // back-to-back forwarding through EX, MEM, WB
        ins(1, 2, 3, 1'b0, 1'b0);
        ins(3, 0, 6, 1'b0, 1'b0);
        ins(3, 0, 7, 1'b0, 1'b0);
        ins(3, 0, 8, 1'b0, 1'b0);
        // double producer and $0
        ins(0, 0, 5, 1'b0, 1'b0);
        ins(0, 0, 5, 1'b0, 1'b0);
        ins(0, 5, 9, 1'b0, 1'b0);
        ins(0, 0, 0, 1'b0, 1'b0);
        ins(0, 0, 10, 1'b0, 1'b0);
        // load-use
        ins(1, 2, 4, 1'b1, 1'b0);
        ins(4, 0, 11, 1'b0, 1'b0);
        ins(4, 0, 11, 1'b0, 1'b0);
        // divider busy
        ins(1, 2, 12, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) ins(13, 14, 15, 1'b0, 1'b0);
        // flush over a load-use hazard
        ins(1, 2, 4, 1'b1, 1'b0);
        step(1'b1, 1'b1, 4, 0, 1'b1, 1'b0, 9, 1'b1, 1'b0, 1'b0, 1'b1);
        ins(9, 4, 16, 1'b0, 1'b0);
        // reset during divider count
        ins(1, 2, 17, 1'b0, 1'b1);
        ins(18, 19, 20, 1'b0, 1'b0);
        step(1'b0, 1'b1, 18, 19, 1'b1, 1'b1, 20, 1'b1, 1'b0, 1'b0, 1'b0);
        ins(17, 17, 21, 1'b0, 1'b0);
        step(1'b1, 1'b0, 17, 17, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        // randomized traffic over a small register window
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 99) >= 2, $urandom_range(0, 99) < 85,
                 $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 7), $urandom_range(0, 9) != 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 8);
        end
        guard = 0;
        while (expq.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        chk("drain", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
